// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the data memory and its initiator.
package data_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_initiator.sv
// Load/store burst sequencer driving the single-port data memory; loads register one beat per cycle, one cycle after the address.
// Loads stall while the response register is held by RspReady=0; stores advance only on WrValid; requests accepted only in IDLE.
module data_mem_initiator
    import data_mem_pkg::*;
#(
    parameter int W = DATA_W,
    parameter int A = ADDR_W,
    parameter int L = LEN_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic [A-1:0] ReqAddr,
    input  logic [L-1:0] ReqLen,
    input  logic         WrValid,
    input  logic [W-1:0] WrData,
    output logic         WrReady,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic         RspLast,
    input  logic         RspReady,
    output logic         Busy,
    output logic [A-1:0] MemAddress,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    state_t       state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [L-1:0] cnt_q, cnt_d;
    logic [W-1:0] rsp_dat_q, rsp_dat_d;
    logic         rsp_vld_q, rsp_vld_d;
    logic         rsp_last_q, rsp_last_d;
    logic         last_beat;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_dat_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    assign last_beat = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_last_d = rsp_last_q;
        ReqReady   = 1'b0;
        WrReady    = 1'b0;
        MemWriteEn = 1'b0;
        MemDataIn  = '0;

        case (state_q)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    cnt_d   = ReqLen;
                    state_d = ReqWrite ? WRITE : READ;
                end
            end

            READ: begin
                // The response register is free when empty or being emptied this cycle.
                if (!rsp_vld_q || RspReady) begin
                    rsp_dat_d  = MemDataOut;
                    rsp_vld_d  = 1'b1;
                    rsp_last_d = last_beat;
                    addr_d     = addr_q + A'(1);
                    if (last_beat) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q - L'(1);
                    end
                end
            end

            DRAIN: begin
                if (RspReady) begin
                    rsp_vld_d  = 1'b0;
                    rsp_last_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            WRITE: begin
                WrReady    = 1'b1;
                MemDataIn  = WrData;
                MemWriteEn = WrValid;
                if (WrValid) begin
                    addr_d = addr_q + A'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - L'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign Busy       = (state_q != IDLE);
    assign MemAddress = addr_q;
    assign RspValid   = rsp_vld_q;
    assign RspData    = rsp_dat_q;
    assign RspLast    = rsp_last_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: behavioural memory plus a reference image and per-burst expectations.
module tb_data_mem_initiator;
    import data_mem_pkg::*;

    localparam int W     = DATA_W;
    localparam int A     = ADDR_W;
    localparam int L     = LEN_W;
    localparam int DEPTH = 1 << A;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         ReqValid, ReqReady, ReqWrite;
    logic [A-1:0] ReqAddr;
    logic [L-1:0] ReqLen;
    logic         WrValid, WrReady;
    logic [W-1:0] WrData;
    logic         RspValid, RspLast, RspReady;
    logic [W-1:0] RspData;
    logic         Busy;
    logic [A-1:0] MemAddress;
    logic         MemWriteEn;
    logic [W-1:0] MemDataIn, MemDataOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    data_mem_initiator #(.W(W), .A(A), .L(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqLen(ReqLen),
        .WrValid(WrValid), .WrData(WrData), .WrReady(WrReady),
        .RspValid(RspValid), .RspData(RspData), .RspLast(RspLast), .RspReady(RspReady),
        .Busy(Busy),
        .MemAddress(MemAddress), .MemWriteEn(MemWriteEn),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    // Memory model with a backdoor port for preloading.
    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] ref_mem [DEPTH];
    logic         bd_we = 1'b0;
    logic [A-1:0] bd_addr = '0;
    logic [W-1:0] bd_data = '0;
    int           wr_count = 0;

    always @(posedge Clk) begin
        if (MemWriteEn) begin
            mem[MemAddress] <= MemDataIn;
            wr_count        <= wr_count + 1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    assign MemDataOut = mem[MemAddress];

    task automatic poke(input int a, input logic [W-1:0] d);
        @(negedge Clk);
        bd_we = 1'b1; bd_addr = A'(a); bd_data = d;
        ref_mem[a % DEPTH] = d;
        @(negedge Clk);
        bd_we = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        n_cmp++;
        if (diffs != 0) begin
            n_err++;
            $display("FAIL %s mem_image: %0d entries differ, want 0", name, diffs);
        end
    endtask

    task automatic run_load(input string name, input int addr, input int len,
                            input int mode, input bit poke_req);
        logic [W-1:0] exp_q[$];
        int n, got, cyc, wr0;
        logic prev_vld, prev_rdy, prev_last;
        logic [W-1:0] prev_dat;
        n = len + 1; got = 0; cyc = 0; wr0 = wr_count;
        prev_vld = 0; prev_rdy = 0; prev_last = 0; prev_dat = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(addr + i) % DEPTH]);

        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = A'(addr); ReqLen = L'(len); RspReady = 1'b1;
        #1;
        n_cmp++;
        if (ReqReady !== 1'b1) begin n_err++; $display("FAIL %s req_ready_idle: got %b want 1", name, ReqReady); end

        while (got < n && cyc < 300) begin
            @(negedge Clk);
            ReqValid = poke_req ? 1'($urandom_range(0, 1)) : 1'b0;
            ReqWrite = 1'($urandom_range(0, 1));
            ReqAddr  = A'($urandom);
            ReqLen   = L'($urandom);
            case (mode)
                0:       RspReady = 1'b1;
                1:       RspReady = (cyc % 2 == 0);
                default: RspReady = 1'($urandom_range(0, 1));
            endcase
            #1;
            n_cmp++;
            if (Busy !== 1'b1 || ReqReady !== 1'b0 || MemWriteEn !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_flags cyc%0d: busy=%b req_ready=%b we=%b want 1/0/0",
                         name, cyc, Busy, ReqReady, MemWriteEn);
            end
            if (cyc <= 1) begin
                n_cmp++;
                if (RspValid !== (cyc == 1)) begin
                    n_err++;
                    $display("FAIL %s first_beat_latency cyc%0d: rsp_valid=%b want %b", name, cyc, RspValid, cyc == 1);
                end
            end
            if (prev_vld && !prev_rdy) begin
                n_cmp++;
                if (RspValid !== 1'b1 || RspData !== prev_dat || RspLast !== prev_last) begin
                    n_err++;
                    $display("FAIL %s stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             name, RspValid, RspData, RspLast, prev_dat, prev_last);
                end
            end
            if (RspValid === 1'b1 && RspReady) begin
                n_cmp++;
                if (RspData !== exp_q[got] || RspLast !== (got == n - 1)) begin
                    n_err++;
                    $display("FAIL %s beat%0d: got d=%h l=%b want d=%h l=%b",
                             name, got, RspData, RspLast, exp_q[got], got == n - 1);
                end
                got++;
            end
            prev_vld = RspValid; prev_rdy = RspReady; prev_dat = RspData; prev_last = RspLast;
            cyc++;
        end
        n_cmp++;
        if (got != n) begin n_err++; $display("FAIL %s beat_count: got %0d want %0d (timeout)", name, got, n); end

        @(negedge Clk);
        ReqValid = 1'b0; RspReady = 1'b0;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || RspValid !== 1'b0 || ReqReady !== 1'b1) begin
            n_err++;
            $display("FAIL %s end_idle: busy=%b rsp_valid=%b req_ready=%b want 0/0/1", name, Busy, RspValid, ReqReady);
        end
        if (mode == 0) begin
            n_cmp++;
            if (cyc != n + 1) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, n + 1); end
        end
        n_cmp++;
        if (wr_count != wr0) begin n_err++; $display("FAIL %s no_writes: got %0d want 0", name, wr_count - wr0); end
    endtask

    task automatic run_store(input string name, input int addr, input int len, input int mode,
                             input int abort_after, input logic [W-1:0] base);
        logic [W-1:0] dat[$];
        int n, i, cyc, wr0, exp_wr;
        logic v;
        bit aborted;
        n = len + 1; i = 0; cyc = 0; wr0 = wr_count; aborted = 0;
        for (int k = 0; k < n; k++) dat.push_back(W'(base + W'(8'h11 * k)));

        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = A'(addr); ReqLen = L'(len);
        #1;
        n_cmp++;
        if (ReqReady !== 1'b1) begin n_err++; $display("FAIL %s req_ready_idle: got %b want 1", name, ReqReady); end

        while (!aborted && i < n && cyc < 300) begin
            @(negedge Clk);
            ReqValid = 1'b0;
            if (abort_after >= 0 && i == abort_after) begin
                aborted = 1;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                WrValid = v;
                WrData  = v ? dat[i] : W'($urandom);
                #1;
                n_cmp++;
                if (Busy !== 1'b1 || WrReady !== 1'b1 || ReqReady !== 1'b0 || MemWriteEn !== v ||
                    MemAddress !== A'(addr + i) || (v && MemDataIn !== dat[i])) begin
                    n_err++;
                    $display("FAIL %s write_cyc%0d: busy=%b wr_rdy=%b we=%b addr=%h din=%h want 1/1/%b addr=%h din=%h",
                             name, cyc, Busy, WrReady, MemWriteEn, MemAddress, MemDataIn, v, A'(addr + i), dat[i]);
                end
                if (v) i++;
                cyc++;
            end
        end

        if (aborted) begin
            WrValid = 1'b1; WrData = dat[i];
            Reset = 1'b0;
            #1;
            n_cmp++;
            if (MemWriteEn !== 1'b0 || WrReady !== 1'b0 || Busy !== 1'b0 || ReqReady !== 1'b1 ||
                MemAddress !== '0 || RspValid !== 1'b0 || RspData !== '0 || RspLast !== 1'b0) begin
                n_err++;
                $display("FAIL %s abort_outputs: we=%b wr_rdy=%b busy=%b req_rdy=%b addr=%h rv=%b want 0/0/0/1/00/0",
                         name, MemWriteEn, WrReady, Busy, ReqReady, MemAddress, RspValid);
            end
            repeat (3) @(negedge Clk);
            Reset = 1'b1; WrValid = 1'b0;
            exp_wr = abort_after;
        end else begin
            n_cmp++;
            if (i != n) begin n_err++; $display("FAIL %s beat_count: got %0d want %0d (timeout)", name, i, n); end
            @(negedge Clk);
            WrValid = 1'b0;
            #1;
            n_cmp++;
            if (Busy !== 1'b0 || ReqReady !== 1'b1 || WrReady !== 1'b0 || MemWriteEn !== 1'b0) begin
                n_err++;
                $display("FAIL %s end_idle: busy=%b req_rdy=%b wr_rdy=%b we=%b want 0/1/0/0",
                         name, Busy, ReqReady, WrReady, MemWriteEn);
            end
            exp_wr = n;
        end
        for (int k = 0; k < exp_wr; k++) ref_mem[(addr + k) % DEPTH] = dat[k];
        n_cmp++;
        if (wr_count - wr0 != exp_wr) begin
            n_err++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_count - wr0, exp_wr);
        end
        mem_check(name);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) poke(i, W'($urandom));
        #1;
        n_cmp++;
        if (ReqReady !== 1'b1 || Busy !== 1'b0 || WrReady !== 1'b0 || MemWriteEn !== 1'b0 ||
            MemAddress !== '0 || RspValid !== 1'b0 || RspData !== '0 || RspLast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: req_rdy=%b busy=%b wr_rdy=%b we=%b addr=%h rv=%b rd=%h rl=%b",
                     ReqReady, Busy, WrReady, MemWriteEn, MemAddress, RspValid, RspData, RspLast);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        WrValid = 1'b1; WrData = 8'h5A;
        #1;
        n_cmp++;
        if (MemWriteEn !== 1'b0 || WrReady !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_wrvalid: we=%b wr_rdy=%b busy=%b want 0/0/0", MemWriteEn, WrReady, Busy);
        end
        @(negedge Clk);
        WrValid = 1'b0;
    endtask

    task automatic test_single_load();
        poke(8'h10, 8'hAB);
        run_load("single_load", 8'h10, 0, 0, 0);
    endtask

    task automatic test_wrap_store();
        logic [W-1:0] exp_vals [4];
        exp_vals[0] = 8'h11; exp_vals[1] = 8'h22; exp_vals[2] = 8'h33; exp_vals[3] = 8'h44;
        run_store("wrap_store", 8'hFE, 3, 0, -1, 8'h11);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (mem[(8'hFE + k) % DEPTH] !== exp_vals[k]) begin
                n_err++;
                $display("FAIL wrap_store mem[%h]: got %h want %h", (8'hFE + k) % DEPTH,
                         mem[(8'hFE + k) % DEPTH], exp_vals[k]);
            end
        end
    endtask

    task automatic test_backpressure_load();
        for (int k = 0; k < 4; k++) poke(8'h20 + k, W'(8'hA0 + k));
        run_load("bp_load", 8'h20, 3, 1, 0);
    endtask

    task automatic test_gapped_store();
        run_store("gapped_store", 8'h40, 2, 1, -1, W'($urandom));
    endtask

    task automatic test_req_while_busy();
        run_load("req_while_busy", 8'h80, 5, 2, 1);
    endtask

    task automatic test_reset_mid_burst();
        run_store("reset_mid_store", 8'h60, 3, 0, 2, 8'h37);
        run_load("load_after_reset", 8'h61, 0, 0, 0);

        // A held response beat must vanish on reset.
        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 8'h30; ReqLen = 4'd3; RspReady = 1'b0;
        @(negedge Clk);
        ReqValid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (RspValid !== 1'b0 || RspData !== '0 || RspLast !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_load: rv=%b rd=%h rl=%b busy=%b want 0/00/0/0", RspValid, RspData, RspLast, Busy);
        end
        @(negedge Clk);
        Reset = 1'b1;
        run_load("load_after_load_reset", 8'h30, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int a, ln, md;
            a  = $urandom_range(0, DEPTH - 1);
            ln = $urandom_range(0, (1 << L) - 1);
            md = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) run_store("rand_store", a, ln, md, -1, W'($urandom));
            else                           run_load("rand_load", a, ln, md, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        Reset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
        WrValid = 1'b0; WrData = '0; RspReady = 1'b0;
        test_reset();
        test_single_load();
        test_wrap_store();
        test_backpressure_load();
        test_gapped_store();
        test_req_while_busy();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

Requester-side sequencer for the single-port data memory. It accepts load/store burst requests from the processor datapath over a valid/ready handshake and drives the memory's address, write-enable and write-data pins. It captures the memory's combinational read data into a back-pressurable response stream. It sits between the core's load/store path and the data memory, and is the only agent that drives the memory port.

## Interface
- W, 8, data width; matches the memory's entry width.
- A, 8, address width; the memory holds 2**A entries.
- L, 4, burst-length field width; a burst is ReqLen+1 beats, 1..2**L.

- Clk  in  1  clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- ReqValid  in  1  a request is offered.
- ReqReady  out  1  the block can accept a request.
- ReqWrite  in  1  1 = store burst, 0 = load burst.
- ReqAddr  in  A  start address.
- ReqLen  in  L  beats minus one.
- WrValid  in  1  store data beat offered.
- WrData  in  W  store data.
- WrReady  out  1  store beat accepted this cycle.
- RspValid  out  1  load data beat present.
- RspData  out  W  load data.
- RspLast  out  1  the current response beat is the last of its burst.
- RspReady  in  1  consumer takes the response beat.
- Busy  out  1  a burst is in progress (state ≠ IDLE).
- MemAddress  out  A  to memory address.
- MemWriteEn  out  1  to memory write enable.
- MemDataIn  out  W  to memory write data.
- MemDataOut  in  W  from memory combinational read data.

## Operation
- States: IDLE, READ, DRAIN, WRITE. Reset state is IDLE.
- Registers:
  - addr (A bits)
  - cnt (L bits)
  - RspData, RspValid, RspLast
- IDLE:
  - ReqReady=1, WrReady=0, MemWriteEn=0.
  - ReqValid&ReqReady latches addr←ReqAddr and cnt←ReqLen.
  - Next state is WRITE if ReqWrite=1, otherwise READ.
- READ:
  - MemAddress=addr.
  - A capture is enabled when !RspValid || RspReady.
  - On a capture: RspData←MemDataOut, RspValid←1, RspLast←(cnt==0), addr←addr+1, cnt←cnt−1.
  - If cnt==0 at the capture, the next state is DRAIN.
  - No capture means addr and cnt hold.
- DRAIN:
  - Holds the last beat.
  - When RspReady=1: RspValid←0, RspLast←0, next state IDLE.
- WRITE:
  - WrReady=1. MemAddress=addr, MemDataIn=WrData, MemWriteEn=WrValid (combinational, WRITE state only).
  - Each WrValid cycle is one beat: addr←addr+1, cnt←cnt−1.
  - A beat with cnt==0 returns the block to IDLE.
- Address arithmetic is mod 2**A: address 2**A−1 wraps to 0 within a burst. cnt never wraps, because the burst ends at 0.
- ReqReady=0 in every state except IDLE. ReqValid outside IDLE is ignored; no request is queued.
- RspValid only clears on RspReady; RspData and RspLast are held stable while RspValid=1 and RspReady=0.
- MemWriteEn is never asserted outside WRITE. Loads and stores never overlap, which respects the memory's read-or-write-per-cycle rule.
- Reset values:
  - state IDLE
  - addr 0, cnt 0
  - RspValid 0, RspData 0, RspLast 0
  - hence ReqReady=1, Busy=0, WrReady=0, MemWriteEn=0, MemAddress=0
- Reset asserted mid-burst aborts it. Writes already clocked remain in memory, with no further write. Any pending response beat is discarded.

## Timing
- Request accepted at edge k. The memory address is valid from edge k. The first load beat is registered at edge k+1, so RspValid=1 in cycle k+1.
- Load throughput is 1 beat/cycle with RspReady held high. An N-beat load with no back-pressure leaves Busy high for N+1 cycles.
- Store: the first memory write can occur at edge k+1 when WrValid=1 in cycle k+1. Throughput is 1 beat/cycle. The return to IDLE is at the edge of the last beat.
- A new request can be accepted in the first cycle back in IDLE. There is no dead cycle beyond that.

## Structure
- Package data_mem_pkg holds:
  - the state enum typedef (IDLE, READ, DRAIN, WRITE)
  - default W, A, L localparams, shared with the memory instance
- Single module; no sub-module is natural. The response register is simple enough to stay inline.

## Test plan
- Single load: memory[0x10]=0xAB; request read addr 0x10, len 0, RspReady=1 → RspValid=1 for one cycle with RspData=0xAB, RspLast=1; Busy falls in the following cycle.
- Wrapping store: write burst at 0xFE, len 3, data 0x11,0x22,0x33,0x44 → memory FE=11, FF=22, 00=33, 01=44; MemWriteEn high for exactly 4 cycles.
- Back-pressured load: read 0x20, len 3, memory 0x20..0x23=A0..A3, RspReady toggled 1/0 → beats A0,A1,A2,A3 in order with none lost or duplicated; RspLast only on A3; data stable while stalled.
- Gapped store: WrValid low every other cycle during a 3-beat write → MemWriteEn follows WrValid; addr advances only on beats; exactly 3 writes.
- Request while busy: ReqValid pulsed during a read burst → ReqReady=0; the request is not executed and the burst completes unchanged.
- Reset mid-store: Reset driven low after 2 of 4 beats → MemWriteEn=0 immediately and all outputs return to their reset values; after release, a fresh single load returns correct data.
